jt51_wr_seq: RTL and testbench
==============================

Name: jt51_wr_seq

Overview:
- Host-side bus initiator that drives the JT51 CPU write port (din/a0/write) and honours the chip's busy flag.
- Accepts (register, value) commands into an internal FIFO.
- Converts each command into an address write (a0=0) followed by a data write (a0=1), then waits for busy to clear before the next one.
- Sits between a CPU or sound-driver command source and the jt51 top-level write interface.

Parameters:
- FIFO_AW, 4, log2 of command FIFO depth (depth = 2**FIFO_AW entries of 16 bits).
- WR_LEN, 1, number of clk cycles write is held high per bus write (1..15).
- GAP, 1, clk cycles with write low between the address write and the data write (1..15).
- ADDR_CACHE, 1, when 1 the address write is skipped if the register equals the last one written.

Ports:
- rst  in  1  asynchronous active-high reset
- clk  in  1  system clock, same clock as the jt51 core
- cmd_addr  in  8  register number
- cmd_data  in  8  register value
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command (not full)
- flush  in  1  discard queued commands and invalidate the address cache
- level  out  FIFO_AW+1  number of queued commands
- idle  out  1  FIFO empty, state IDLE, busy low
- dout  out  8  to jt51 din
- a0  out  1  to jt51 a0
- write  out  1  to jt51 write
- busy  in  1  from jt51 busy

Behaviour:
- Reset values: cmd_ready=1, level=0, idle=1 (provided busy is low), dout=0, a0=0, write=0.
  - State is IDLE; FIFO pointers are 0; the address cache is invalid.
  - Reset asserted mid-operation aborts immediately; write drops in the same cycle, asynchronously.
- FIFO:
  - A push happens when cmd_valid & cmd_ready.
  - cmd_ready = (level < depth), registered, with no combinational dependence on pop.
  - A push when full is ignored.
  - There is no bypass: an entry is visible to the state machine one edge after it is pushed.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo depth.
- flush:
  - Clears the pointers and level and invalidates the cache on the same edge.
  - A push in the same cycle is discarded.
  - A transaction already in progress completes normally.
- State machine, with all outputs registered:
  - IDLE: write=0. If the FIFO is not empty and busy=0 and flush=0, pop into the hold registers.
    - If ADDR_CACHE=1, the cache is valid and the address equals the cached address, go to DATA.
    - Otherwise go to ADDR.
  - ADDR: dout=addr, a0=0, write=1 for WR_LEN cycles. Then load the cache with addr, mark it valid, and go to GAP.
  - GAP: write=0, a0=0, dout held, for GAP cycles, then go to DATA.
  - DATA: dout=data, a0=1, write=1 for WR_LEN cycles, then go to SETTLE.
  - SETTLE: write=0, a0 held at 1, for 2 cycles. busy is ignored here because the jt51 raises busy one edge after the write rising edge. Then go to IDLE.
  - IDLE then gates the next pop on busy=0.
- Latency:
  - A command pushed at edge E0 is popped at E1, and write is high after E1.
  - Minimum command period with cache miss = WR_LEN + GAP + WR_LEN + 2 + 1 cycles, plus the busy wait.
  - With a cache hit, the GAP and the address write are removed.
- dout holds its last value in IDLE; a0 returns to 0 on entry to IDLE.
- idle = (level==0) & (state==IDLE) & !busy.
- busy held high indefinitely stalls in IDLE; no timeout.

Test Plan:
1. Reset, then push (0x28, 0x4A) with busy low:
   - One edge after acceptance, write=1, a0=0, dout=0x28 for 1 cycle; write=0 for 1 cycle.
   - Then write=1, a0=1, dout=0x4A for 1 cycle; then SETTLE.
   - level returns to 0.
2. Push (0x60,0x10) then (0x60,0x20) with ADDR_CACHE=1:
   - The second command produces only the data write (a0=1, dout=0x20) and no a0=0 write.
   - With ADDR_CACHE=0, both commands produce an address write.
3. Hold busy=1 for 64 cycles after the first data write, with 3 commands queued:
   - No write pulse while busy=1.
   - The next address write starts within 2 edges of busy falling.
4. Push 16 commands with busy=1 (FIFO_AW=4):
   - level=16 and cmd_ready=0.
   - A 17th cmd_valid is not accepted.
   - After busy falls, all 16 commands are emitted in order.
5. Assert flush while the data write of command 1 is in progress with 5 queued:
   - The data write completes.
   - level=0 and idle=1 after busy clears.
   - A following (0x60,x) command produces an address write, because the cache was invalidated.
6. Assert rst during the ADDR write:
   - write and a0 go to 0 immediately, level=0.
   - After release, the next command starts from an address write.

Source files
------------

// File: rtl/jt51_wr_seq.sv
// jt51_wr_seq: queues (register, value) commands and plays each one out on the
// JT51 CPU write port as an address write followed by a data write. Before it
// starts the next command it waits for the chip's busy flag to clear.
module jt51_wr_seq #(
  parameter int FIFO_AW    = 4,
  parameter int WR_LEN     = 1,
  parameter int GAP        = 1,
  parameter int ADDR_CACHE = 1
) (
  input  logic               rst,
  input  logic               clk,
  input  logic [7:0]         cmd_addr,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               flush,
  output logic [FIFO_AW:0]   level,
  output logic               idle,
  output logic [7:0]         dout,
  output logic               a0,
  output logic               write,
  input  logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_SETTLE} state_t;

  logic [15:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ready_q;
  logic               push, pop;
  logic [15:0]        head;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d, data_q, data_d;
  logic [7:0]         cache_q, cache_d;
  logic               cache_vld_q, cache_vld_d;
  logic [7:0]         dout_q, dout_d;
  logic               a0_q, a0_d, wr_q, wr_d;

  // A flush cycle drops any command offered alongside it.
  assign push = cmd_valid & ready_q & ~flush;
  assign head = mem_q[rd_ptr_q];

  // Occupancy update; a flush overrides both push and pop.
  always_comb begin
    level_d = level_q;
    if (flush)
      level_d = '0;
    else if (push && !pop)
      level_d = level_q + (FIFO_AW+1)'(1);
    else if (!push && pop)
      level_d = level_q - (FIFO_AW+1)'(1);
  end

  // FIFO control: pointers, level and a registered not-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      level_q <= level_d;
      ready_q <= (level_d < (FIFO_AW+1)'(DEPTH));
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + (FIFO_AW)'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW)'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
  end

  // Sequencer next state; bus outputs are computed for the coming cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    dout_d      = dout_q;
    a0_d        = a0_q;
    wr_d        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        a0_d = 1'b0;
        if (level_q != '0 && !busy && !flush) begin
          pop    = 1'b1;
          addr_d = head[15:8];
          data_d = head[7:0];
          cnt_d  = 4'(WR_LEN - 1);
          wr_d   = 1'b1;
          if (ADDR_CACHE != 0 && cache_vld_q && cache_q == head[15:8]) begin
            state_d = S_DATA;
            dout_d  = head[7:0];
            a0_d    = 1'b1;
          end else begin
            state_d = S_ADDR;
            dout_d  = head[15:8];
          end
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) begin
          cache_d     = addr_q;
          cache_vld_d = 1'b1;
          state_d     = S_GAP;
          cnt_d       = 4'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
          wr_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          cnt_d   = 4'(WR_LEN - 1);
          dout_d  = data_q;
          a0_d    = 1'b1;
          wr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 4'd0) begin
          // The chip raises busy a cycle late, so give it two cycles to show.
          state_d = S_SETTLE;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          wr_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          a0_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) cache_vld_d = 1'b0;
  end

  // Sequencer control and bus outputs; reset aborts the bus cycle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cache_vld_q <= 1'b0;
      dout_q      <= 8'd0;
      a0_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cache_vld_q <= cache_vld_d;
      dout_q      <= dout_d;
      a0_q        <= a0_d;
      wr_q        <= wr_d;
    end
  end

  // Command hold registers and cached register number.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    data_q  <= data_d;
    cache_q <= cache_d;
  end

  assign cmd_ready = ready_q;
  assign level     = level_q;
  assign idle      = (level_q == '0) && (state_q == S_IDLE) && !busy;
  assign dout      = dout_q;
  assign a0        = a0_q;
  assign write     = wr_q;

endmodule

// File: tb/tb_jt51_wr_seq.sv
// Bench for jt51_wr_seq: one instance with the address cache, one without.
module tb_jt51_wr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m, rst_n;
  logic [7:0] cmd_addr, cmd_data;
  logic       cmd_valid;
  logic       flush_m, flush_n, busy;

  logic       cmd_ready_m, idle_m, a0_m, write_m;
  logic [4:0] level_m;
  logic [7:0] dout_m;
  logic       cmd_ready_n, idle_n, a0_n, write_n;
  logic [4:0] level_n;
  logic [7:0] dout_n;

  jt51_wr_seq #(.FIFO_AW(4), .WR_LEN(1), .GAP(1), .ADDR_CACHE(1)) u_cache (
    .rst(rst_m), .clk(clk), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_m), .flush(flush_m),
    .level(level_m), .idle(idle_m), .dout(dout_m), .a0(a0_m),
    .write(write_m), .busy(busy));

  jt51_wr_seq #(.FIFO_AW(4), .WR_LEN(1), .GAP(1), .ADDR_CACHE(0)) u_nocache (
    .rst(rst_n), .clk(clk), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_n), .flush(flush_n),
    .level(level_n), .idle(idle_n), .dout(dout_n), .a0(a0_n),
    .write(write_n), .busy(busy));

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Observed bus writes {a0, dout}, one entry per cycle with write high.
  logic [8:0]  obs_m[$], obs_n[$];
  // Expected bus writes produced by the reference model.
  logic [8:0]  exp_m[$], exp_n[$];
  // Accepted commands not yet turned into expected bus writes.
  logic [15:0] pend_m[$], pend_n[$];
  logic        cvld_m;
  logic [7:0]  caddr_m;

  always @(negedge clk) begin
    if (!rst_m && write_m) obs_m.push_back({a0_m, dout_m});
    if (!rst_n && write_n) obs_n.push_back({a0_n, dout_n});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every command writes its register number unless the
  // cache already holds it, then writes its value.
  function automatic void commit_m(input logic [15:0] c);
    if (!(cvld_m && caddr_m == c[15:8])) exp_m.push_back({1'b0, c[15:8]});
    exp_m.push_back({1'b1, c[7:0]});
    cvld_m  = 1'b1;
    caddr_m = c[15:8];
  endfunction

  function automatic void commit_n(input logic [15:0] c);
    exp_n.push_back({1'b0, c[15:8]});
    exp_n.push_back({1'b1, c[7:0]});
  endfunction

  function automatic void drain();
    while (pend_m.size() > 0) commit_m(pend_m.pop_front());
    while (pend_n.size() > 0) commit_n(pend_n.pop_front());
  endfunction

  function automatic void flush_model_m(input int keep);
    for (int i = 0; i < keep; i++) commit_m(pend_m.pop_front());
    pend_m.delete();
    cvld_m = 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input bit acc);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    if (acc) begin
      pend_m.push_back({a, d});
      pend_n.push_back({a, d});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    busy = 1'b0;
    n = 0;
    step();
    while (!(idle_m && idle_n) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, idle_m && idle_n}, 32'd1);
  endtask

  task automatic wait_datawr(input string tag);
    int n;
    n = 0;
    while (!(write_m && a0_m) && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_datawr"}, {31'd0, write_m && a0_m}, 32'd1);
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    drain();
    chk({tag, "_m_len"}, obs_m.size(), exp_m.size());
    n = (obs_m.size() < exp_m.size()) ? obs_m.size() : exp_m.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_m[%0d]", tag, i), {23'd0, obs_m[i]}, {23'd0, exp_m[i]});
    chk({tag, "_n_len"}, obs_n.size(), exp_n.size());
    n = (obs_n.size() < exp_n.size()) ? obs_n.size() : exp_n.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_n[%0d]", tag, i), {23'd0, obs_n[i]}, {23'd0, exp_n[i]});
    obs_m.delete(); exp_m.delete();
    obs_n.delete(); exp_n.delete();
  endtask

  initial begin
    int nw;
    logic [7:0] ra, rd;
    rst_m = 1'b1; rst_n = 1'b1;
    cmd_addr = 8'd0; cmd_data = 8'd0; cmd_valid = 1'b0;
    flush_m = 1'b0; flush_n = 1'b0; busy = 1'b0;
    cvld_m = 1'b0; caddr_m = 8'd0;
    repeat (3) step();

    // Reset values
    chk("rst_ready", {31'd0, cmd_ready_m}, 32'd1);
    chk("rst_level", {27'd0, level_m}, 32'd0);
    chk("rst_idle",  {31'd0, idle_m}, 32'd1);
    chk("rst_dout",  {24'd0, dout_m}, 32'd0);
    chk("rst_a0",    {31'd0, a0_m}, 32'd0);
    chk("rst_write", {31'd0, write_m}, 32'd0);
    rst_m = 1'b0; rst_n = 1'b0;
    step();

    // Single command, cycle by cycle
    push(8'h28, 8'h4A, 1'b1);
    chk("t1_lvl1", {27'd0, level_m}, 32'd1);
    chk("t1_wr0",  {31'd0, write_m}, 32'd0);
    step();
    chk("t1_aw_wr", {31'd0, write_m}, 32'd1);
    chk("t1_aw_a0", {31'd0, a0_m}, 32'd0);
    chk("t1_aw_do", {24'd0, dout_m}, 32'h28);
    step();
    chk("t1_gap_wr", {31'd0, write_m}, 32'd0);
    chk("t1_gap_a0", {31'd0, a0_m}, 32'd0);
    chk("t1_gap_do", {24'd0, dout_m}, 32'h28);
    step();
    chk("t1_dw_wr", {31'd0, write_m}, 32'd1);
    chk("t1_dw_a0", {31'd0, a0_m}, 32'd1);
    chk("t1_dw_do", {24'd0, dout_m}, 32'h4A);
    chk("t1_lvl0",  {27'd0, level_m}, 32'd0);
    step();
    chk("t1_st1_wr", {31'd0, write_m}, 32'd0);
    chk("t1_st1_a0", {31'd0, a0_m}, 32'd1);
    step();
    chk("t1_st2_a0",   {31'd0, a0_m}, 32'd1);
    chk("t1_st2_idle", {31'd0, idle_m}, 32'd0);
    step();
    chk("t1_end_a0",   {31'd0, a0_m}, 32'd0);
    chk("t1_end_idle", {31'd0, idle_m}, 32'd1);
    chk("t1_end_do",   {24'd0, dout_m}, 32'h4A);
    cmp_queues("t1");

    // Repeated register: only the cached instance skips the address write
    push(8'h60, 8'h10, 1'b1);
    push(8'h60, 8'h20, 1'b1);
    wait_idle("t2");
    cmp_queues("t2");

    // Busy stalls the sequencer between commands
    push(8'h30, 8'h01, 1'b1);
    push(8'h31, 8'h02, 1'b1);
    push(8'h32, 8'h03, 1'b1);
    push(8'h33, 8'h04, 1'b1);
    wait_datawr("t3");
    chk("t3_do", {24'd0, dout_m}, 32'h01);
    busy = 1'b1;
    nw = 0;
    step();
    chk("t3_lvl", {27'd0, level_m}, 32'd3);
    for (int i = 0; i < 63; i++) begin
      if (write_m) nw++;
      step();
    end
    if (write_m) nw++;
    chk("t3_nowrite", nw, 32'd0);
    busy = 1'b0;
    nw = 0;
    while (!write_m && nw < 10) begin
      step();
      nw++;
    end
    chk("t3_resume", {31'd0, (nw <= 2) && write_m && !a0_m}, 32'd1);
    wait_idle("t3");
    cmp_queues("t3");

    // Fill the FIFO while busy
    busy = 1'b1;
    for (int i = 0; i < 16; i++)
      push(8'h40 + 8'(i / 4), 8'(8'h80 + i), 1'b1);
    chk("t4_lvl_m",   {27'd0, level_m}, 32'd16);
    chk("t4_ready_m", {31'd0, cmd_ready_m}, 32'd0);
    chk("t4_lvl_n",   {27'd0, level_n}, 32'd16);
    chk("t4_ready_n", {31'd0, cmd_ready_n}, 32'd0);
    chk("t4_nowr",    {31'd0, write_m}, 32'd0);
    push(8'h55, 8'h55, 1'b0);
    chk("t4_lvl17", {27'd0, level_m}, 32'd16);
    wait_idle("t4");
    cmp_queues("t4");

    // Flush during the data write of the first of six commands
    busy = 1'b1;
    push(8'h60, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++)
      push(8'h60, 8'(8'h02 + i), 1'b1);
    busy = 1'b0;
    wait_datawr("t5");
    chk("t5_do",  {24'd0, dout_m}, 32'h01);
    chk("t5_lvl", {27'd0, level_m}, 32'd5);
    flush_m = 1'b1;
    step();
    flush_m = 1'b0;
    flush_model_m(1);
    chk("t5_lvl0",  {27'd0, level_m}, 32'd0);
    chk("t5_ready", {31'd0, cmd_ready_m}, 32'd1);
    busy = 1'b1;
    repeat (3) step();
    chk("t5_idle_busy", {31'd0, idle_m}, 32'd0);
    chk("t5_nowr", {31'd0, write_m}, 32'd0);
    busy = 1'b0;
    #1;
    chk("t5_idle", {31'd0, idle_m}, 32'd1);
    push(8'h60, 8'h77, 1'b1);
    wait_idle("t5");
    cmp_queues("t5");

    // Reset during an address write
    push(8'h11, 8'h01, 1'b1);
    wait_idle("t6a");
    cmp_queues("t6a");
    push(8'h12, 8'h02, 1'b1);
    push(8'h13, 8'h03, 1'b1);
    chk("t6_inaw", {31'd0, write_m && !a0_m}, 32'd1);
    chk("t6_lvl1", {27'd0, level_m}, 32'd1);
    rst_m = 1'b1;
    #1;
    chk("t6_wr",    {31'd0, write_m}, 32'd0);
    chk("t6_a0",    {31'd0, a0_m}, 32'd0);
    chk("t6_lvl",   {27'd0, level_m}, 32'd0);
    chk("t6_ready", {31'd0, cmd_ready_m}, 32'd1);
    pend_m.delete();
    cvld_m = 1'b0;
    step();
    rst_m = 1'b0;
    step();
    push(8'h11, 8'h33, 1'b1);
    wait_idle("t6");
    cmp_queues("t6");

    // Randomized commands over a small register set with random busy
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        busy = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 3)) begin
          step();
          busy = ($urandom_range(0, 3) == 0);
        end
        ra = 8'h20 + 8'($urandom_range(0, 3));
        rd = 8'($urandom_range(0, 255));
        push(ra, rd, 1'b1);
      end
      wait_idle($sformatf("rnd%0d", r));
      cmp_queues($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
